register_serializer: RTL

REGISTER_SERIALIZER -- requirements
Module: register_serializer

---
 rtl/register_serializer.sv | 92 +++++++++
 1 files changed

// File: rtl/register_serializer.sv
// Parallel-to-serial shifter with a valid/ready serial port and
// first/last bit markers. A word is captured on load while idle and
// shifted out one bit per accepted transfer. A one-cycle done pulse
// follows the final transfer.
module register_serializer #(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sof,
    output logic             eof,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx;
    logic             accept;
    logic             xfer;
    logic             last;

    // cnt never reaches WIDTH, so idx always stays inside the word
    assign last = (cnt == CW'(WIDTH - 1));
    assign idx  = (MSB_FIRST != 0) ? (CW'(WIDTH - 1) - cnt) : cnt;

    // State register; async reset drops straight back to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and all handshake/marker outputs, purely from state
    // and counter so that an async reset clears them without a clock edge
    always_comb begin
        state_nx   = state;
        ready      = 1'b0;
        accept     = 1'b0;
        xfer       = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;
        case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = load;
                if (load) state_nx = SHIFT;
            end
            SHIFT: begin
                sout_valid = 1'b1;
                xfer       = sout_ready;
                sout       = sreg[idx];
                sof        = (cnt == '0);
                eof        = last;
                if (sout_ready && last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, advance only on a real transfer so a
    // stall freezes the bit on sout; the last transfer leaves cnt alone
    // (the next accept clears it) and raises done for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= xfer && last;
            if (accept) begin
                sreg <= d;
                cnt  <= '0;
            end else if (xfer && !last) begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule
